signed_divider: RTL and testbench

Sequential two's-complement divider forming the inverse arithmetic path to the team's Booth multiplier. It divides a 2W-bit dividend by a W-bit divisor, producing a W-bit quotient and a W-bit remainder. Internally it runs a restoring shift/subtract loop on operand magnitudes, one bit per cycle, and applies signs at the end. It sits in the datapath ALU cluster next to the multiplier and uses a start/done handshake toward the controlling FSM.

---
 rtl/signed_divider.sv | 174 +++++++++++++++++
 tb/tb_signed_divider.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_divider.sv
// signed_divider: sequential divider of a 2W-bit dividend by a W-bit divisor
// giving a W-bit quotient and a W-bit remainder. A restoring shift/subtract
// loop runs on operand magnitudes, one quotient bit per cycle, and signs are
// applied in a final fixup cycle.
//
// Build option: define DIV_SIGNED_EN for two's-complement operands. Without
// it the block divides unsigned operands with the same ports, states and
// latency.
//
// Handshake: start is sampled only in IDLE. The accepting edge latches the
// operands, clears the result outputs and raises busy. done pulses for one
// cycle as busy falls, and the results, div_zero and overflow then hold
// until the next accepted start. A start seen while busy is ignored. A
// start still high while done is high is accepted on the next edge,
// because the block is already back in IDLE.
module signed_divider #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2*W-1:0]   dividend,
   input  logic [W-1:0]     divisor,
   output logic [W-1:0]     quotient,
   output logic [W-1:0]     remainder,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic             overflow,
   output logic [1:0]       state_dbg
);

   localparam int CW = $clog2(2*W+1);
   localparam logic [2*W-1:0] LIM_POS = (2*W)'((1 << (W-1)) - 1);
   localparam logic [2*W-1:0] LIM_NEG = (2*W)'(1 << (W-1));
   localparam logic [2*W-1:0] LIM_UNS = (2*W)'((1 << W) - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FIXUP  = 2'd2
   } state_t;

   state_t          state, state_nx;

   // Qm starts as the dividend magnitude and is shifted left one bit per
   // step, with the new quotient bits entering at the LSB.
   logic [2*W-1:0]  qm;
   logic [W-1:0]    dm;
   // The partial remainder is always below Dm, so only W bits need storage;
   // the extra trial bit lives in t/diff.
   logic [W-1:0]    r;
   logic [CW-1:0]   count;
   logic            sign_q, sign_r, dz_pend;

   logic [W:0]      t, diff;
   logic            last_step;
   logic            sq_in, sr_in;
   logic [2*W-1:0]  dvd_mag;
   logic [W-1:0]    dvs_mag;
   logic [2*W-1:0]  limit;
   logic            too_big;

   assign state_dbg = state;

`ifdef DIV_SIGNED_EN
   // Operand signs and magnitudes; the most negative dividend negates to
   // itself and is then read as the unsigned magnitude 2^(2W-1).
   always_comb begin
      sq_in   = dividend[2*W-1] ^ divisor[W-1];
      sr_in   = dividend[2*W-1];
      dvd_mag = dividend[2*W-1] ? -dividend : dividend;
      dvs_mag = divisor[W-1] ? -divisor : divisor;
      limit   = sign_q ? LIM_NEG : LIM_POS;
   end
`else
   // Unsigned operands pass through unchanged and results are never negated.
   always_comb begin
      sq_in   = 1'b0;
      sr_in   = 1'b0;
      dvd_mag = dividend;
      dvs_mag = divisor;
      limit   = LIM_UNS;
   end
`endif

   // One restoring step: trial-subtract the divisor from the shifted remainder.
   always_comb begin
      t         = {r, qm[2*W-1]};
      diff      = t - {1'b0, dm};
      last_step = (count == CW'(2*W-1));
      too_big   = (qm > limit);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = (divisor == '0) ? FIXUP : DIVIDE;
         DIVIDE:  if (last_step) state_nx = FIXUP;
         FIXUP:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qm        <= '0;
         dm        <= '0;
         r         <= '0;
         count     <= '0;
         sign_q    <= 1'b0;
         sign_r    <= 1'b0;
         dz_pend   <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sign_q    <= sq_in;
                  sign_r    <= sr_in;
                  qm        <= dvd_mag;
                  dm        <= dvs_mag;
                  r         <= '0;
                  count     <= '0;
                  dz_pend   <= (divisor == '0);
                  quotient  <= '0;
                  remainder <= '0;
                  div_zero  <= 1'b0;
                  overflow  <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            DIVIDE: begin
               if (!diff[W]) begin
                  r  <= diff[W-1:0];
                  qm <= {qm[2*W-2:0], 1'b1};
               end else begin
                  r  <= t[W-1:0];
                  qm <= {qm[2*W-2:0], 1'b0};
               end
               count <= count + CW'(1);
            end
            FIXUP: begin
               done <= 1'b1;
               busy <= 1'b0;
               if (dz_pend) begin
                  div_zero <= 1'b1;
               end else if (too_big) begin
                  overflow <= 1'b1;
               end else begin
                  quotient  <= sign_q ? -qm[W-1:0] : qm[W-1:0];
                  remainder <= sign_r ? -r : r;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider.sv
// tb_signed_divider: directed vectors against an arithmetic reference model
// (integer divide/modulo with range checks), a per-cycle output checker fed
// from an expected-result queue, and handshake/reset scenarios.
module tb_signed_divider;

   localparam int W  = 4;
   localparam int EW = 2*W + 2;

   logic             clk;
   logic             reset;
   logic             start;
   logic [2*W-1:0]   dividend;
   logic [W-1:0]     divisor;
   logic [W-1:0]     quotient;
   logic [W-1:0]     remainder;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic             overflow;
   logic [1:0]       state_dbg;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] last_exp = '0;

   signed_divider #(.W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .quotient  (quotient),
      .remainder (remainder),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .overflow  (overflow),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Returns {quotient, remainder, div_zero, overflow}.
   function automatic logic [EW-1:0] model(input logic [2*W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, q, r;
      logic [W-1:0] qv, rv;
`ifdef DIV_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = a;
      sb = b;
`endif
      if (sb == 0) return {{(2*W){1'b0}}, 2'b10};
      q = sa / sb;
      r = sa % sb;
`ifdef DIV_SIGNED_EN
      if (q > (2**(W-1)) - 1 || q < -(2**(W-1))) return {{(2*W){1'b0}}, 2'b01};
`else
      if (q > (2**W) - 1) return {{(2*W){1'b0}}, 2'b01};
`endif
      qv = q[W-1:0];
      rv = r[W-1:0];
      return {qv, rv, 2'b00};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard / per-cycle compare ----------------
   always @(negedge clk) begin
      logic [EW-1:0] act, e;
      act = {quotient, remainder, div_zero, overflow};
      if (reset === 1'b1) begin
         if (done) begin
            check("done_busy_low", 16'(busy), 16'd0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got %h want none", act);
            end else begin
               e = exp_q.pop_front();
               check("result", 16'(act), 16'(e));
               last_exp = e;
            end
         end else if (busy) begin
            check("cleared_while_busy", 16'(act), 16'd0);
         end else begin
            check("held_result", 16'(act), 16'(last_exp));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit hold);
      @(negedge clk);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      exp_q.push_back(model(a, b));
      @(negedge clk);
      if (!hold) begin
         start    = 1'b0;
         dividend = 8'($urandom_range(0, 255));
         divisor  = 4'($urandom_range(0, 15));
      end
      t0 = cyc;
      check("busy_after_accept", 16'({busy, done}), 16'b10);
   endtask

   task automatic wait_done(input int exp_lat, input string name);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         check({name, "_busy"}, 16'(busy), 16'd1);
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got no done want done", name);
      end else begin
         check({name, "_latency"}, 16'(cyc - t0), 16'(exp_lat));
      end
   endtask

   task automatic run_vec(input logic [2*W-1:0] a, input logic [W-1:0] b, input string name);
      start_op(a, b, 1'b0);
      wait_done((b == '0) ? 1 : 2*W+1, name);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;

      // Model pins: hand-computed results.
`ifdef DIV_SIGNED_EN
      check("pin_45_7",    16'(model(8'h2D, 4'h7)), 16'({4'h6, 4'h3, 2'b00}));
      check("pin_m45_7",   16'(model(8'hD3, 4'h7)), 16'({4'hA, 4'hD, 2'b00}));
      check("pin_45_m7",   16'(model(8'h2D, 4'h9)), 16'({4'hA, 4'h3, 2'b00}));
      check("pin_m45_m7",  16'(model(8'hD3, 4'h9)), 16'({4'h6, 4'hD, 2'b00}));
      check("pin_64_m8",   16'(model(8'h40, 4'h8)), 16'({4'h8, 4'h0, 2'b00}));
      check("pin_64_7",    16'(model(8'h40, 4'h7)), 16'({4'h0, 4'h0, 2'b01}));
      check("pin_m128_m1", 16'(model(8'h80, 4'hF)), 16'({4'h0, 4'h0, 2'b01}));
`else
      check("pin_45_7",    16'(model(8'h2D, 4'h7)), 16'({4'h6, 4'h3, 2'b00}));
      check("pin_64_8",    16'(model(8'h40, 4'h8)), 16'({4'h8, 4'h0, 2'b00}));
      check("pin_211_7",   16'(model(8'hD3, 4'h7)), 16'({4'h0, 4'h0, 2'b01}));
      check("pin_128_15",  16'(model(8'h80, 4'hF)), 16'({4'h8, 4'h8, 2'b00}));
`endif
      check("pin_div0",    16'(model(8'h2D, 4'h0)), 16'({4'h0, 4'h0, 2'b10}));

      // Reset state.
      #1;
      check("reset_outputs", 16'({busy, done, quotient, remainder, div_zero, overflow, state_dbg}), 16'd0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;

      // Directed vectors.
      run_vec(8'h2D, 4'h7, "pos_45_7");
      run_vec(8'hD3, 4'h7, "neg_dividend");
      run_vec(8'h2D, 4'h9, "neg_divisor");
      run_vec(8'hD3, 4'h9, "both_neg");
      run_vec(8'h40, 4'h8, "lim_64_8");
      run_vec(8'h40, 4'h7, "ovf_64_7");
      run_vec(8'h80, 4'hF, "ovf_m128_m1");
      run_vec(8'h2D, 4'h0, "div_zero");
      run_vec(8'h00, 4'h5, "zero_dividend");
      run_vec(8'hFD, 4'h7, "small_neg");
      run_vec(8'h80, 4'h8, "m128_m8");
      run_vec(8'h7F, 4'h1, "ovf_127_1");
      run_vec(8'hF9, 4'h8, "m7_m8");

      // Start pulse during DIVIDE cycle 4 is ignored.
      start_op(8'h2D, 4'h7, 1'b0);
      repeat (3) @(negedge clk);
      start    = 1'b1;
      dividend = 8'h13;
      divisor  = 4'h3;
      @(negedge clk);
      start    = 1'b0;
      wait_done(2*W+1, "ignored_start");

      // Start held through done: second op accepted on the edge after done.
      start_op(8'h2D, 4'h7, 1'b1);
      wait_done(2*W+1, "held_first");
      dividend = 8'hD3;
      divisor  = 4'h9;
      exp_q.push_back(model(8'hD3, 4'h9));
      @(negedge clk);
      start = 1'b0;
      check("held_second_accept", 16'(cyc - t0), 16'(2*W+2));
      t0 = cyc;
      check("held_second_busy", 16'(busy), 16'd1);
      wait_done(2*W+1, "held_second");

      // Reset during DIVIDE cycle 5.
      start_op(8'h2D, 4'h7, 1'b0);
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      exp_q.delete();
      last_exp = '0;
      #1;
      check("midop_reset", 16'({busy, done, quotient, remainder, div_zero, overflow, state_dbg}), 16'd0);
      @(negedge clk);
      #2 reset = 1'b1;
      run_vec(8'h2D, 4'h7, "after_reset");

      repeat (3) @(negedge clk);
      check("queue_empty", 16'(exp_q.size()), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
